// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcode/func
// constants, ALU command encodings and the decoder's instruction-class record.
package mc_control_unit_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_e;

    localparam logic [4:0] RA_REG = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_HAMD = 6'b110000;

    // Bit 3 set only for shifts and hamd.
    localparam logic [3:0] ALUC_ADD  = 4'b0000;
    localparam logic [3:0] ALUC_SUB  = 4'b0100;
    localparam logic [3:0] ALUC_AND  = 4'b0001;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0010;
    localparam logic [3:0] ALUC_LUI  = 4'b0110;
    localparam logic [3:0] ALUC_SLL  = 4'b0011;
    localparam logic [3:0] ALUC_SRL  = 4'b0111;
    localparam logic [3:0] ALUC_SRA  = 4'b1111;
    localparam logic [3:0] ALUC_HAMD = 4'b1011;

    localparam logic [1:0] PCS_PC4    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_RS     = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    typedef struct packed {
        logic [3:0] aluc;
        logic       rtype;
        logic       itype_alu;
        logic       load;
        logic       store;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       jr;
        logic       jal;
        logic       shift;
        logic       sext;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/mc_control_unit_alu_op_decoder.sv
// alu_op_decoder: combinational op/func -> ALU command plus instruction-class
// flags consumed by the control FSM.
module alu_op_decoder
    import mc_control_unit_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec
);

    always_comb begin
        dec       = '0;
        dec.legal = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec.rtype = 1'b1;
                case (func)
                    FN_ADD:  dec.aluc = ALUC_ADD;
                    FN_SUB:  dec.aluc = ALUC_SUB;
                    FN_AND:  dec.aluc = ALUC_AND;
                    FN_OR:   dec.aluc = ALUC_OR;
                    FN_XOR:  dec.aluc = ALUC_XOR;
                    FN_HAMD: dec.aluc = ALUC_HAMD;
                    FN_SLL:  begin dec.aluc = ALUC_SLL; dec.shift = 1'b1; end
                    FN_SRL:  begin dec.aluc = ALUC_SRL; dec.shift = 1'b1; end
                    FN_SRA:  begin dec.aluc = ALUC_SRA; dec.shift = 1'b1; end
                    FN_JR:   dec.jr = 1'b1;
                    default: begin dec.legal = 1'b0; dec.rtype = 1'b0; end
                endcase
            end
            OP_ADDI: begin dec.itype_alu = 1'b1; dec.aluc = ALUC_ADD; dec.sext = 1'b1; end
            OP_ANDI: begin dec.itype_alu = 1'b1; dec.aluc = ALUC_AND; end
            OP_ORI:  begin dec.itype_alu = 1'b1; dec.aluc = ALUC_OR;  end
            OP_XORI: begin dec.itype_alu = 1'b1; dec.aluc = ALUC_XOR; end
            OP_LUI:  begin dec.itype_alu = 1'b1; dec.aluc = ALUC_LUI; end
            OP_LW:   begin dec.load  = 1'b1; dec.aluc = ALUC_ADD; dec.sext = 1'b1; end
            OP_SW:   begin dec.store = 1'b1; dec.aluc = ALUC_ADD; dec.sext = 1'b1; end
            OP_BEQ:  begin dec.branch = 1'b1; dec.aluc = ALUC_SUB; end
            OP_BNE:  begin dec.branch = 1'b1; dec.bne = 1'b1; dec.aluc = ALUC_SUB; end
            OP_J:    dec.jump = 1'b1;
            OP_JAL:  dec.jal  = 1'b1;
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle IF/ID/EX/MEM/WB control FSM. Define MC_CTRL_ILLEGAL_TRAP_EN to make
// undecoded instructions set a sticky illegal flag and park in TRAP.
module mc_control_unit
    import mc_control_unit_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic [3:0] aluc,
    output logic       pc_en,
    output logic [1:0] pcsource,
    output logic       ir_en,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       aluimm,
    output logic       shift,
    output logic       sext,
    output logic       jal,
    output logic [2:0] state,
    output logic       illegal
);

    state_e state_q, state_d;
    dec_t   dec;

    alu_op_decoder u_dec (
        .op   (op),
        .func (func),
        .dec  (dec)
    );

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam state_e ILLEGAL_NEXT = S_TRAP;
    logic illegal_q, illegal_d;

    always_comb illegal_d = illegal_q | ((state_q == S_ID) & ~dec.legal);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) illegal_q <= 1'b0;
        else         illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`else
    localparam state_e ILLEGAL_NEXT = S_IF;
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IF;
        else         state_q <= state_d;
    end

    assign state = state_q;

    // Memory handshake: mem_rd/mem_wr stay high until mem_ready is seen in the
    // same cycle; mem_ready in any state other than IF/MEM is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:  if (mem_ready) state_d = S_ID;
            S_ID: begin
                if (!dec.legal)                state_d = ILLEGAL_NEXT;
                else if (dec.jump || dec.jr)   state_d = S_IF;
                else if (dec.jal)              state_d = S_WB;
                else                           state_d = S_EX;
            end
            S_EX: begin
                if (dec.branch)                state_d = S_IF;
                else if (dec.load | dec.store) state_d = S_MEM;
                else                           state_d = S_WB;
            end
            S_MEM: if (mem_ready) state_d = dec.load ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    // Outputs are forced low while resetn is asserted so no partial access leaks out.
    always_comb begin
        aluc     = ALUC_ADD;
        pc_en    = 1'b0;
        pcsource = PCS_PC4;
        ir_en    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        wreg     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        aluimm   = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        jal      = 1'b0;
        if (resetn) begin
            case (state_q)
                S_IF: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_en = 1'b1;
                        pc_en = 1'b1;
                    end
                end
                S_ID: begin
                    if (dec.jump) begin
                        pc_en    = 1'b1;
                        pcsource = PCS_JUMP;
                    end else if (dec.jr) begin
                        pc_en    = 1'b1;
                        pcsource = PCS_RS;
                    end
                end
                S_EX: begin
                    aluc   = dec.aluc;
                    shift  = dec.shift;
                    sext   = dec.sext;
                    aluimm = dec.itype_alu | dec.load | dec.store;
                    if (dec.branch) begin
                        pc_en    = dec.bne ? ~z : z;
                        pcsource = PCS_BRANCH;
                    end
                end
                S_MEM: begin
                    mem_rd = dec.load;
                    mem_wr = dec.store;
                end
                S_WB: begin
                    wreg  = 1'b1;
                    regrt = ~dec.rtype & ~dec.jal;
                    m2reg = dec.load;
                    if (dec.jal) begin
                        jal      = 1'b1;
                        pc_en    = 1'b1;
                        pcsource = PCS_JUMP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: directed instruction sequences, an instruction-level
// model that expands each instruction into its expected per-cycle outputs, and a checker.
`timescale 1ns/1ps
module tb_mc_control_unit;

    typedef struct packed {
        logic [2:0] state;
        logic [3:0] aluc;
        logic       pc_en;
        logic [1:0] pcsource;
        logic       ir_en;
        logic       mem_rd;
        logic       mem_wr;
        logic       wreg;
        logic       regrt;
        logic       m2reg;
        logic       aluimm;
        logic       shift;
        logic       sext;
        logic       jal;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic       mem_ready;
        logic       z;
        logic [5:0] op;
        logic [5:0] func;
        obs_t       exp;
    } step_t;

    typedef enum {K_ALU_R, K_SHIFT, K_ALU_I, K_ALU_IS, K_LW, K_SW, K_BEQ, K_BNE,
                  K_J, K_JR, K_JAL, K_BAD} kind_e;

    // ---------------- clock / reset / DUT ----------------
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] func = '0;
    logic       z = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] aluc;
    logic       pc_en, ir_en, mem_rd, mem_wr, wreg, regrt, m2reg, aluimm, shift, sext, jal, illegal;
    logic [1:0] pcsource;
    logic [2:0] state;

    always #5 clock = ~clock;

    mc_control_unit dut (
        .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
        .aluc(aluc), .pc_en(pc_en), .pcsource(pcsource), .ir_en(ir_en), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .wreg(wreg), .regrt(regrt), .m2reg(m2reg), .aluimm(aluimm),
        .shift(shift), .sext(sext), .jal(jal), .state(state), .illegal(illegal)
    );

    obs_t act;
    assign act = {state, aluc, pc_en, pcsource, ir_en, mem_rd, mem_wr, wreg, regrt, m2reg,
                  aluimm, shift, sext, jal, illegal};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [20:0] exp_q[$];
    step_t       steps[$];

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, a, e);
        end
    endtask

    // ---------------- instruction-level model ----------------
    function automatic kind_e kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: begin
                case (f)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b110000: return K_ALU_R;
                    6'b000000, 6'b000010, 6'b000011: return K_SHIFT;
                    6'b001000: return K_JR;
                    default:   return K_BAD;
                endcase
            end
            6'b001000: return K_ALU_IS;
            6'b001100, 6'b001101, 6'b001110, 6'b001111: return K_ALU_I;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000101: return K_BNE;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_BAD;
        endcase
    endfunction

    function automatic logic [3:0] aluc_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000000) begin
            case (f)
                6'b100000: return 4'b0000;
                6'b100010: return 4'b0100;
                6'b100100: return 4'b0001;
                6'b100101: return 4'b0101;
                6'b100110: return 4'b0010;
                6'b000000: return 4'b0011;
                6'b000010: return 4'b0111;
                6'b000011: return 4'b1111;
                6'b110000: return 4'b1011;
                default:   return 4'b0000;
            endcase
        end
        case (o)
            6'b001100: return 4'b0001;
            6'b001101: return 4'b0101;
            6'b001110: return 4'b0010;
            6'b001111: return 4'b0110;
            6'b000100, 6'b000101: return 4'b0100;
            default:   return 4'b0000;
        endcase
    endfunction

    task automatic push(input logic [5:0] o, input logic [5:0] f, input logic zz,
                        input logic rdy, input obs_t e);
        step_t s;
        s.op = o; s.func = f; s.z = zz; s.mem_ready = rdy; s.exp = e;
        steps.push_back(s);
    endtask

    // Expands one instruction into expected per-cycle outputs with the given wait states.
    task automatic gen_instr(input logic [5:0] o, input logic [5:0] f, input logic zz,
                             input int if_wait, input int mem_wait);
        kind_e k;
        obs_t  e;
        k = kind_of(o, f);
        for (int i = 0; i < if_wait; i++) begin
            e = '0; e.mem_rd = 1'b1;
            push(o, f, zz, 1'b0, e);
        end
        e = '0; e.mem_rd = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1;
        push(o, f, zz, 1'b1, e);
        e = '0; e.state = 3'd1;
        if (k == K_J)  begin e.pc_en = 1'b1; e.pcsource = 2'b11; end
        if (k == K_JR) begin e.pc_en = 1'b1; e.pcsource = 2'b10; end
        push(o, f, zz, 1'b1, e);
        if (k == K_J || k == K_JR) return;
        if (k == K_BAD) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 10; i++) begin
                e = '0; e.state = 3'd5; e.illegal = 1'b1;
                push(o, f, zz, i[0], e);
            end
`endif
            return;
        end
        if (k != K_JAL) begin
            e = '0; e.state = 3'd2; e.aluc = aluc_of(o, f);
            e.aluimm = (k == K_ALU_I || k == K_ALU_IS || k == K_LW || k == K_SW);
            e.sext   = (k == K_ALU_IS || k == K_LW || k == K_SW);
            e.shift  = (k == K_SHIFT);
            if (k == K_BEQ) begin e.pc_en = zz;  e.pcsource = 2'b01; end
            if (k == K_BNE) begin e.pc_en = !zz; e.pcsource = 2'b01; end
            push(o, f, zz, 1'b1, e);
            if (k == K_BEQ || k == K_BNE) return;
        end
        if (k == K_LW || k == K_SW) begin
            e = '0; e.state = 3'd3; e.mem_rd = (k == K_LW); e.mem_wr = (k == K_SW);
            for (int i = 0; i < mem_wait; i++) push(o, f, zz, 1'b0, e);
            push(o, f, zz, 1'b1, e);
            if (k == K_SW) return;
        end
        e = '0; e.state = 3'd4; e.wreg = 1'b1;
        e.regrt = (k == K_ALU_I || k == K_ALU_IS || k == K_LW);
        e.m2reg = (k == K_LW);
        if (k == K_JAL) begin e.jal = 1'b1; e.pc_en = 1'b1; e.pcsource = 2'b11; end
        push(o, f, zz, 1'b1, e);
    endtask

    // ---------------- driver ----------------
    task automatic run_n(input int n);
        step_t s;
        for (int i = 0; i < n && steps.size() > 0; i++) begin
            s = steps.pop_front();
            @(negedge clock);
            op = s.op; func = s.func; z = s.z; mem_ready = s.mem_ready;
            exp_q.push_back(s.exp);
        end
    endtask

    task automatic run_all();
        run_n(steps.size());
    endtask

    task automatic pin_len(input string name, input int n);
        check(name, steps.size(), n);
        run_all();
    endtask

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        #2;
        cyc++;
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL cycle%0d outputs act=%h exp=%h (state act=%0d exp=%0d)",
                         cyc, act, e, act[20:18], e[20:18]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        #1;
        check("reset_outputs", {11'd0, act}, 32'd0);
        repeat (2) @(negedge clock);
        check("reset_held", {11'd0, act}, 32'd0);
        resetn = 1'b1;

        check("model_aluc_hamd", {28'd0, aluc_of(6'b000000, 6'b110000)}, 32'h0000000b);
        check("model_aluc_sra",  {28'd0, aluc_of(6'b000000, 6'b000011)}, 32'h0000000f);

        gen_instr(6'b000000, 6'b100000, 1'b0, 0, 0); pin_len("len_add", 4);
        gen_instr(6'b000100, 6'b000000, 1'b1, 0, 0); pin_len("len_beq_taken", 3);
        gen_instr(6'b000100, 6'b000000, 1'b0, 0, 0); pin_len("len_beq_not", 3);
        gen_instr(6'b000101, 6'b000000, 1'b1, 0, 0); run_all();
        gen_instr(6'b100011, 6'b000000, 1'b0, 1, 2); pin_len("len_lw_waits", 8);
        gen_instr(6'b000000, 6'b110000, 1'b0, 0, 0); run_all();
        gen_instr(6'b000000, 6'b000011, 1'b0, 0, 0); run_all();
        gen_instr(6'b000000, 6'b000000, 1'b0, 0, 0); run_all();
        gen_instr(6'b001000, 6'b101010, 1'b0, 0, 0); run_all();
        gen_instr(6'b001100, 6'b000000, 1'b1, 0, 0); run_all();
        gen_instr(6'b001111, 6'b000000, 1'b0, 0, 0); run_all();
        gen_instr(6'b101011, 6'b000000, 1'b0, 0, 1); run_all();
        gen_instr(6'b101011, 6'b000000, 1'b0, 0, 0); pin_len("len_sw", 4);
        gen_instr(6'b000010, 6'b000000, 1'b0, 0, 0); pin_len("len_j", 2);
        gen_instr(6'b000000, 6'b001000, 1'b0, 2, 0); run_all();
        gen_instr(6'b000011, 6'b000000, 1'b0, 0, 0); pin_len("len_jal", 3);
        gen_instr(6'b000000, 6'b100110, 1'b1, 0, 0); run_all();
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        gen_instr(6'b111111, 6'b000000, 1'b0, 0, 0); pin_len("len_bad_nop", 2);
        gen_instr(6'b000000, 6'b111111, 1'b0, 0, 0); run_all();
`endif

        // Reset asserted while a store sits in EX.
        gen_instr(6'b101011, 6'b000000, 1'b0, 0, 0);
        run_n(3);
        steps.delete();
        #3 resetn = 1'b0;
        #1;
        check("reset_in_ex_state", {29'd0, state}, 32'd0);
        check("reset_in_ex_outputs", {11'd0, act}, 32'd0);
        @(negedge clock);
        #1;
        check("reset_hold_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("reset_hold_illegal", {31'd0, illegal}, 32'd0);
        mem_ready = 1'b0;
        resetn = 1'b1;
        gen_instr(6'b000000, 6'b100101, 1'b0, 0, 0); pin_len("len_or_after_reset", 4);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        gen_instr(6'b111111, 6'b000000, 1'b0, 0, 0); pin_len("len_bad_trap", 12);
        @(negedge clock);
        #3 resetn = 1'b0;
        #1;
        check("trap_reset_illegal", {31'd0, illegal}, 32'd0);
        check("trap_reset_state", {29'd0, state}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
`endif

        repeat (2) @(negedge clock);
        #5;
        check("exp_queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control FSM that issues commands to the datapath ALU, which executes them.
- Sequences each instruction through IF/ID/EX/MEM/WB.
- Decodes op/func from the instruction register into the 4-bit aluc command and datapath enables.
- Consumes the ALU zero flag to resolve branches.
- Sits between instruction/data memory handshake and the register-file/ALU datapath.

Parameters:
- RA_REG, 5'd31, link register index driven on wdst_sel for jal.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- op  input  6  instruction [31:26], from IR.
- func  input  6  instruction [5:0], from IR.
- z  input  1  ALU zero flag.
- mem_ready  input  1  memory access complete (IF fetch and MEM data).
- aluc  output  4  ALU command.
- pc_en  output  1  PC write enable.
- pcsource  output  2  00 pc+4, 01 branch target, 10 rs (jr), 11 jump target.
- ir_en  output  1  IR load enable.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request.
- wreg  output  1  register-file write enable.
- regrt  output  1  destination is rt (I-type).
- m2reg  output  1  writeback from memory.
- aluimm  output  1  ALU b = immediate.
- shift  output  1  ALU a = shamt.
- sext  output  1  sign-extend immediate.
- jal  output  1  writeback of pc+4 to RA_REG.
- state  output  3  current state, for debug.
- illegal  output  1  illegal-instruction flag.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5.
- Reset (async, resetn=0): state=IF; illegal=0; all enables 0; aluc=0000.
- Outputs are decoded from state+op+func. In EX, pc_en additionally depends combinationally on z.
- aluc encoding:
  - add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110.
  - sll 0011, srl 0111, sra 1111, hamd 1011.
  - Bit 3 = 0 for all non-shift/non-hamd ops.
- Supported instructions:
  - R-type (op=0): add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000, hamd 110000.
  - I-type: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111.
  - J-type: j 000010, jal 000011.
- IF: mem_rd=1. Hold while mem_ready=0. On mem_ready=1: ir_en=1, pc_en=1, pcsource=00, go to ID.
- ID:
  - j: pc_en=1, pcsource=11 -> IF.
  - jr: pc_en=1, pcsource=10 -> IF.
  - jal -> WB.
  - Illegal opcode -> see Optional Feature.
  - All others -> EX.
- EX:
  - aluc per instruction.
  - beq/bne: aluc=sub; pc_en=(z for beq, !z for bne); pcsource=01 -> IF.
  - lw/sw: aluc=add, aluimm=1, sext=1 -> MEM.
  - Other ALU instructions -> WB.
  - shift=1 for sll/srl/sra.
  - sext=1 for addi; andi/ori/xori zero-extend.
- MEM:
  - lw: mem_rd=1.
  - sw: mem_wr=1.
  - Hold while mem_ready=0.
  - On ready: lw -> WB, sw -> IF.
- WB: wreg=1 for one cycle; regrt for I-type; m2reg for lw -> IF.
  - jal: wreg=1, jal=1, pc_en=1, pcsource=11.
- Cycle counts with zero wait states: R/I ALU 4, lw 5, sw 4, beq/bne 3, j/jr 2, jal 3.
- At most one of mem_rd/mem_wr asserted per cycle. wreg is never asserted outside WB.
- Reset mid-operation: immediate return to IF with all enables low. No partial write is allowed to complete.
- mem_ready asserted outside IF/MEM is ignored.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an undecoded op/func in ID sets illegal=1 (sticky) and enters TRAP. TRAP keeps all enables low until resetn.
- Undefined: undecoded instructions execute as NOP (ID -> IF, no writes). illegal ties to 0 and TRAP is unreachable.

Decomposition:
- Shared header mc_ctrl_defs.vh holds:
  - state codes;
  - opcode and func constants;
  - ALUC_* command constants, shared with the ALU and the bench.
- Sub-module alu_op_decoder: combinational op/func -> aluc, instruction-class flags (rtype, itype_alu, load, store, branch, jump, legal). The FSM instantiates it once.

Test Plan:
- add (op=0, func=100000), mem_ready=1 -> states IF,ID,EX,WB. aluc=0000 in EX. wreg=1 only in cycle 4. Back to IF in cycle 5.
- beq with z=1, then with z=0 -> EX shows aluc=0100, pcsource=01. pc_en=1 only when z=1. 3 cycles each.
- lw with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_rd=1. Then WB with m2reg=1, regrt=1, wreg=1.
- hamd (func=110000) -> aluc=1011 in EX. sra -> aluc=1111, shift=1.
- op=111111:
  - with MC_CTRL_ILLEGAL_TRAP_EN: illegal=1, state=5 persists for 10 cycles.
  - without: ID -> IF, no wreg/mem_wr.
- resetn pulsed low during EX of sw -> state=IF asynchronously. mem_wr never asserted. illegal=0.
